record_packer: RTL and testbench
================================

# record_packer

Upstream feeder for the EVEN_ODD sorting network. Accepts a stream of one DATW-bit record per cycle and packs 2^P_LOG consecutive records into one wide block. Emits each block as a single-cycle DOTEN pulse that drives the network's DIN/DINEN directly. Partial blocks at end-of-stream (DINLAST) or on FLUSH are padded with all-ones records, which sort to the tail; DOTCNT reports the count of real records.

## Interface
- P_LOG, 4: log2 of records per block; must match the downstream network.
- DATW, 64: record width in bits.
- KEYW, 32: key width, key = record[KEYW-1:0]. Not used for packing; carried so parameter sets match the network.
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- DIN  in  DATW  input record.
- DINEN  in  1  record valid; accepted only when DIN_RDY=1.
- DINLAST  in  1  qualifies DINEN; marks the final record of a stream.
- FLUSH  in  1  pads and emits the current partial block.
- DIN_RDY  out  1  input ready; registered.
- DOT  out  DATW<<P_LOG  packed block; lane i = bits [DATW*(i+1)-1:DATW*i].
- DOTEN  out  1  one-cycle block-valid pulse.
- DOTCNT  out  P_LOG+1  number of real records in DOT, range 1..2^P_LOG.
- DOTLAST  out  1  block closed by DINLAST.

## Operation
- Accept = DINEN & DIN_RDY. A record presented while DIN_RDY=0 is dropped, with no other effect.
- Internal state:
  - fill counter `cnt`, P_LOG+1 bits, range 0..2^P_LOG-1 between blocks.
  - buffer register `buf`, DATW<<P_LOG bits.
- On accept: the record is written to lane `cnt`; the first record of a block goes to lane 0.
- Close condition: a block closes in the same cycle as any of:
  - an accept at `cnt`=2^P_LOG-1 (full);
  - an accept with DINLAST=1;
  - FLUSH=1 with `cnt`>0, or with an accept in that cycle.
- On close, with n = real records including the one accepted this cycle:
  - DOT ← buf with lanes n..2^P_LOG-1 forced to all-ones and lanes 0..n-1 taken from buf/the new record;
  - DOTCNT ← n;
  - DOTLAST ← (accept & DINLAST);
  - DOTEN ← 1;
  - `cnt` ← 0.
- Otherwise: DOTEN ← 0; DOT, DOTCNT and DOTLAST hold their last values; `cnt` increments on accept.
- FLUSH with `cnt`=0 and no accept is a no-op; no empty block is ever emitted.
- A full block accepted with DINLAST=1 is emitted unpadded with DOTCNT=2^P_LOG and DOTLAST=1.
- FLUSH and DINLAST together: a single close, DOTLAST=1.
- After a close, the next accepted record starts a new block at lane 0 with no bubble; back-to-back blocks are allowed.
- Two FSM states:
  - RESET_HOLD: DIN_RDY=0. Exits to RUN on the first cycle with RST=0.
  - RUN: DIN_RDY=1.
- Output rate ≤ 1 block per 2^P_LOG cycles, except flush/last, which can give 1 block per cycle. The network has no back-pressure, so no output stall exists.

## Timing
- Reset (RST=1 at an edge), values after that edge:
  - DIN_RDY=0, DOTEN=0, DOTCNT=0, DOTLAST=0, DOT=0, `cnt`=0, state RESET_HOLD;
  - buf contents are don't-care.
- DIN_RDY becomes 1 at the first edge with RST=0, so the first accept is possible in the cycle after reset deasserts.
- Reset mid-block discards the partial block; no DOTEN.
- Latency: record accepted at edge t completing a block → DOTEN=1 and DOT valid in the cycle after edge t, for exactly one cycle.
- Latency from first record to DOTEN: 2^P_LOG cycles at full rate.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
1. P_LOG=2, DATW=8, KEYW=8. Reset, then records 0x11,0x22,0x33,0x44 on consecutive cycles → one DOTEN pulse the cycle after 0x44; DOT=0x44332211, DOTCNT=4, DOTLAST=0.
2. Records 0x05,0x06 with DINLAST on 0x06 → DOT=0xFFFF0605, DOTCNT=2, DOTLAST=1. A following record 0x07 lands in lane 0 of the next block.
3. Record 0x09, idle 3 cycles, then FLUSH → DOT=0xFFFFFF09, DOTCNT=1, DOTLAST=0. A second FLUSH with no data → no DOTEN.
4. Eight records 0x01..0x08 back-to-back → two pulses 4 cycles apart: DOT=0x04030201, then 0x08070605, with no dropped cycle.
5. RST pulse after 3 records, then 4 records 0xA0..0xA3 → the first 3 records never appear; DIN_RDY=0 for the cycle after reset; the next block is 0xA3A2A1A0.
6. DINEN held high during RESET_HOLD with 0xEE → record dropped; the first emitted block does not contain 0xEE.

Source files
------------

// File: rtl/record_packer_if.sv
// Record stream in, packed block out: the bus between a record source,
// record_packer and the downstream sorting network.
interface record_packer_if #(
    parameter int unsigned P_LOG = 4,
    parameter int unsigned DATW  = 64
);
    logic [DATW-1:0]          DIN;
    logic                     DINEN;
    logic                     DINLAST;
    logic                     FLUSH;
    logic                     DIN_RDY;
    logic [(DATW<<P_LOG)-1:0] DOT;
    logic                     DOTEN;
    logic [P_LOG:0]           DOTCNT;
    logic                     DOTLAST;

    modport master (
        output DIN, DINEN, DINLAST, FLUSH,
        input  DIN_RDY, DOT, DOTEN, DOTCNT, DOTLAST
    );

    modport slave (
        input  DIN, DINEN, DINLAST, FLUSH,
        output DIN_RDY, DOT, DOTEN, DOTCNT, DOTLAST
    );
endinterface

// File: rtl/record_packer.sv
// Packs 2^P_LOG consecutive records into one wide block for the sorting network;
// partial blocks (last/flush) are padded with all-ones records that sort to the tail.
module record_packer #(
    parameter int unsigned P_LOG = 4,
    parameter int unsigned DATW  = 64,
    parameter int unsigned KEYW  = 32
) (
    input logic            CLK,
    input logic            RST,
    record_packer_if.slave bus
);
    localparam int unsigned LANES = 1 << P_LOG;
    localparam int unsigned BW    = DATW * LANES;
    localparam int unsigned CW    = P_LOG + 1;

    typedef logic [CW-1:0]    cnt_t;
    typedef logic [P_LOG-1:0] lane_t;

    // Pad record: key field saturated so pads sort last; payload bits are ones too.
    localparam logic [DATW-1:0] KEY_MASK =
        (KEYW >= DATW) ? {DATW{1'b1}} : ((DATW'(1) << KEYW) - DATW'(1));
    localparam logic [DATW-1:0] PAD_REC = KEY_MASK | ~KEY_MASK;

    typedef enum logic {
        RESET_HOLD = 1'b0,
        RUN        = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          rdy_q, rdy_d;
    cnt_t          cnt_q, cnt_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [BW-1:0] dot_q, dot_d;
    logic          doten_q, doten_d;
    cnt_t          dotcnt_q, dotcnt_d;
    logic          dotlast_q, dotlast_d;

    logic          accept;
    logic          close;
    cnt_t          fill_n;

    // Next-state: FSM, lane write, block close and padding
    always_comb begin
        state_d   = state_q;
        rdy_d     = 1'b0;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        dot_d     = dot_q;
        doten_d   = 1'b0;
        dotcnt_d  = dotcnt_q;
        dotlast_d = dotlast_q;
        accept    = 1'b0;
        close     = 1'b0;
        fill_n    = cnt_q;

        case (state_q)
            RESET_HOLD: state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = RESET_HOLD;
        endcase
        rdy_d = (state_d == RUN);

        accept = bus.DINEN & rdy_q;
        if (accept) begin
            fill_n = cnt_q + cnt_t'(1);
            cnt_d  = cnt_q + cnt_t'(1);
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_t'(i) == cnt_q[P_LOG-1:0]) begin
                    buf_d[i*DATW +: DATW] = bus.DIN;
                end
            end
        end

        close = (accept && ((cnt_q == cnt_t'(LANES - 1)) || bus.DINLAST || bus.FLUSH))
              || (bus.FLUSH && (cnt_q != '0));

        if (close) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                dot_d[i*DATW +: DATW] = (cnt_t'(i) < fill_n) ? buf_d[i*DATW +: DATW] : PAD_REC;
            end
            doten_d   = 1'b1;
            dotcnt_d  = fill_n;
            dotlast_d = accept & bus.DINLAST;
            cnt_d     = '0;
        end
    end

    // Control and output registers, synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RESET_HOLD;
            rdy_q     <= 1'b0;
            cnt_q     <= '0;
            dot_q     <= '0;
            doten_q   <= 1'b0;
            dotcnt_q  <= '0;
            dotlast_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= rdy_d;
            cnt_q     <= cnt_d;
            dot_q     <= dot_d;
            doten_q   <= doten_d;
            dotcnt_q  <= dotcnt_d;
            dotlast_q <= dotlast_d;
        end
    end

    // Lane buffer needs no reset: lanes beyond the fill count are never emitted
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
    end

    assign bus.DIN_RDY = rdy_q;
    assign bus.DOT     = dot_q;
    assign bus.DOTEN   = doten_q;
    assign bus.DOTCNT  = dotcnt_q;
    assign bus.DOTLAST = dotlast_q;
endmodule

// File: tb/tb_record_packer.sv
// Directed bench for record_packer with P_LOG=2, DATW=8: hand-computed blocks,
// padding, flush, back-to-back blocks, and reset behaviour.
module tb_record_packer;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    record_packer_if #(.P_LOG(2), .DATW(8)) bus ();

    record_packer #(.P_LOG(2), .DATW(8), .KEYW(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs at the negedge; return 1 time unit after the posedge.
    task automatic step(input logic [7:0] d, input logic en, input logic last, input logic fl);
        @(negedge clk);
        bus.DIN     = d;
        bus.DINEN   = en;
        bus.DINLAST = last;
        bus.FLUSH   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_block(input string tag, input logic [31:0] dot,
                               input logic [31:0] cnt, input logic last);
        check({tag, "_doten"}, 32'(bus.DOTEN), 32'd1);
        check({tag, "_dot"}, bus.DOT, dot);
        check({tag, "_dotcnt"}, 32'(bus.DOTCNT), cnt);
        check({tag, "_dotlast"}, 32'(bus.DOTLAST), 32'(last));
    endtask

    initial begin
        clk = 1'b0;
        checks = 0;
        passes = 0;
        // Reset with a record held valid throughout (must be dropped)
        rst = 1'b1;
        bus.DIN = 8'hEE;
        bus.DINEN = 1'b1;
        bus.DINLAST = 1'b0;
        bus.FLUSH = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rdy", 32'(bus.DIN_RDY), 32'd0);
        check("rst_doten", 32'(bus.DOTEN), 32'd0);
        check("rst_dotcnt", 32'(bus.DOTCNT), 32'd0);
        check("rst_dotlast", 32'(bus.DOTLAST), 32'd0);
        check("rst_dot", bus.DOT, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("hold_rdy", 32'(bus.DIN_RDY), 32'd1);
        check("hold_doten", 32'(bus.DOTEN), 32'd0);

        // Full block at full rate
        step(8'h11, 1, 0, 0);
        step(8'h22, 1, 0, 0);
        step(8'h33, 1, 0, 0);
        check("t1_noearly", 32'(bus.DOTEN), 32'd0);
        step(8'h44, 1, 0, 0);
        check_block("t1", 32'h44332211, 32'd4, 1'b0);
        step(8'h00, 0, 0, 0);
        check("t1_pulse", 32'(bus.DOTEN), 32'd0);
        check("t1_hold", bus.DOT, 32'h44332211);

        // DINLAST partial block, then next record starts at lane 0
        step(8'h05, 1, 0, 0);
        step(8'h06, 1, 1, 0);
        check_block("t2", 32'hFFFF0605, 32'd2, 1'b1);
        step(8'h07, 1, 0, 0);
        check("t2_nx_doten", 32'(bus.DOTEN), 32'd0);
        step(8'h00, 0, 0, 1);
        check_block("t2_nx", 32'hFFFFFF07, 32'd1, 1'b0);

        // Record, idle, FLUSH; then FLUSH while empty is a no-op
        step(8'h09, 1, 0, 0);
        step(8'h00, 0, 0, 0);
        step(8'h00, 0, 0, 0);
        step(8'h00, 0, 0, 0);
        check("t3_idle", 32'(bus.DOTEN), 32'd0);
        step(8'h00, 0, 0, 1);
        check_block("t3", 32'hFFFFFF09, 32'd1, 1'b0);
        step(8'h00, 0, 0, 1);
        check("t3_empty_doten", 32'(bus.DOTEN), 32'd0);
        check("t3_empty_hold", bus.DOT, 32'hFFFFFF09);
        check("t3_empty_cnt", 32'(bus.DOTCNT), 32'd1);

        // Two back-to-back blocks
        step(8'h01, 1, 0, 0);
        step(8'h02, 1, 0, 0);
        step(8'h03, 1, 0, 0);
        step(8'h04, 1, 0, 0);
        check_block("t4a", 32'h04030201, 32'd4, 1'b0);
        step(8'h05, 1, 0, 0);
        check("t4_gap5", 32'(bus.DOTEN), 32'd0);
        step(8'h06, 1, 0, 0);
        step(8'h07, 1, 0, 0);
        check("t4_gap7", 32'(bus.DOTEN), 32'd0);
        step(8'h08, 1, 0, 0);
        check_block("t4b", 32'h08070605, 32'd4, 1'b0);

        // Reset mid-block discards the partial block
        step(8'h31, 1, 0, 0);
        step(8'h32, 1, 0, 0);
        step(8'h33, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.DINEN = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_doten", 32'(bus.DOTEN), 32'd0);
        check("t5_rst_rdy", 32'(bus.DIN_RDY), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rdy", 32'(bus.DIN_RDY), 32'd1);
        check("t5_doten", 32'(bus.DOTEN), 32'd0);
        step(8'hA0, 1, 0, 0);
        step(8'hA1, 1, 0, 0);
        step(8'hA2, 1, 0, 0);
        check("t5_noearly", 32'(bus.DOTEN), 32'd0);
        step(8'hA3, 1, 0, 0);
        check_block("t5", 32'hA3A2A1A0, 32'd4, 1'b0);

        // FLUSH and DINLAST together: a single close
        step(8'h55, 1, 1, 1);
        check_block("t7", 32'hFFFFFF55, 32'd1, 1'b1);
        step(8'h00, 0, 0, 0);
        check("t7_single", 32'(bus.DOTEN), 32'd0);

        // Full block closed by DINLAST: unpadded
        step(8'hC1, 1, 0, 0);
        step(8'hC2, 1, 0, 0);
        step(8'hC3, 1, 0, 0);
        step(8'hC4, 1, 1, 0);
        check_block("t8", 32'hC4C3C2C1, 32'd4, 1'b1);
        step(8'h00, 0, 0, 0);
        check("t8_pulse", 32'(bus.DOTEN), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
